modport_router: RTL and testbench



---
 rtl/modport_router.sv | 231 +++++++++++++++++++++++
 tb/tb_modport_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modport_router.sv
// modport_router: byte-stream packet router with three output FIFOs.
// A header byte selects the port (data_in[1:0]). Payload and parity bytes
// follow, and the router checks parity over header plus payload.
// Handshake: the sender presents data_in/pkt_valid and keeps them stable
// while busy=1. A byte is consumed on the rising edge of any cycle where
// busy=0. Reads: read_enb[i] with v_out[i]=1 pops one byte, which shows up
// on data_out[8i+7:8i] after the edge.
// Optional build macro MODPORT_ROUTER_SOFT_RESET_EN: this adds a per-port
// watchdog that flushes a FIFO after it has been left unread for TIMEOUT
// cycles.
// fsm_state exposes the controller state for observation.
module modport_router #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        pkt_valid,
    input  logic [2:0]  read_enb,
    output logic [23:0] data_out,
    output logic [2:0]  v_out,
    output logic        busy,
    output logic        error,
    output logic [2:0]  fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        DECODE     = 3'd0,
        WAIT_EMPTY = 3'd1,
        LOAD       = 3'd2,
        CHECK      = 3'd3,
        DROP       = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    port;
    logic [7:0]    header;
    logic [7:0]    parity_acc;
    logic [7:0]    parity_rx;

    logic [7:0]    mem [3][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [CW-1:0] count  [3];

    logic [2:0]    full;
    logic [2:0]    empty;
    logic [2:0]    wr_en;
    logic [2:0]    rd_en;
    logic [2:0]    flush;
    logic [7:0]    wr_data;

    // Pick one port's flag; address 3 never maps to a FIFO.
    function automatic logic sel3(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    // FIFO occupancy flags come from the count registers.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]  = (count[i] == CW'(FIFO_DEPTH));
            empty[i] = (count[i] == '0);
        end
    end

    assign v_out     = ~empty;
    assign fsm_state = state;

    // Sender back-pressure. It uses the current full flag, so a same-cycle pop
    // does not release it.
    always_comb begin
        busy = 1'b0;
        case (state)
            WAIT_EMPTY: busy = 1'b1;
            CHECK:      busy = 1'b1;
            LOAD:       busy = sel3(full, port);
            default:    busy = 1'b0;
        endcase
    end

    // Write selection. In WAIT_EMPTY the sender has already moved past the
    // header, so the latched copy is written once the port drains. That cycle
    // still reports busy because no data_in byte is taken.
    always_comb begin
        wr_en   = '0;
        wr_data = data_in;
        case (state)
            DECODE: begin
                if (pkt_valid && data_in[1:0] != 2'd3 && !sel3(full, data_in[1:0]))
                    wr_en = 3'(3'b001 << data_in[1:0]);
            end
            WAIT_EMPTY: begin
                if (sel3(empty, port)) begin
                    wr_en   = 3'(3'b001 << port);
                    wr_data = header;
                end
            end
            LOAD: begin
                if (!sel3(full, port))
                    wr_en = 3'(3'b001 << port);
            end
            default: wr_en = '0;
        endcase
        wr_en = wr_en & ~flush;
    end

    // A pop happens only when the port has data.
    always_comb begin
        rd_en = read_enb & ~empty;
    end

`ifdef MODPORT_ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer [3];

    // A port flushes on the edge where its idle-unread count reaches TIMEOUT.
    always_comb begin
        for (int i = 0; i < 3; i++)
            flush[i] = v_out[i] && !read_enb[i] && (timer[i] == TW'(TIMEOUT - 1));
    end

    // Per-port idle counters: count while data waits unread, clear otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) timer[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (v_out[i] && !read_enb[i] && !flush[i])
                    timer[i] <= timer[i] + TW'(1);
                else
                    timer[i] <= '0;
            end
        end
    end
`else
    // Without the watchdog, FIFO contents persist until they are read.
    always_comb begin
        flush = '0;
    end
`endif

    // FIFO storage. It is not reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (wr_en[i]) mem[i][wr_ptr[i]] <= wr_data;
    end

    // FIFO pointers, counts and the registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            data_out <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (rd_en[i]) begin
                    data_out[8*i +: 8] <= mem[i][rd_ptr[i]];
                    rd_ptr[i]          <= rd_ptr[i] + AW'(1);
                end
                if (flush[i]) begin
                    count[i]  <= '0;
                    rd_ptr[i] <= wr_ptr[i];
                end else begin
                    count[i] <= count[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
                end
            end
        end
    end

    // Packet controller: framing, parity accumulation and the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DECODE;
            port       <= '0;
            header     <= '0;
            parity_acc <= '0;
            parity_rx  <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        if (data_in[1:0] == 2'd3) begin
                            state <= DROP;
                        end else begin
                            port       <= data_in[1:0];
                            header     <= data_in;
                            parity_acc <= data_in;
                            state      <= sel3(full, data_in[1:0]) ? WAIT_EMPTY : LOAD;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (sel3(empty, port)) state <= LOAD;
                end
                LOAD: begin
                    if (!sel3(full, port)) begin
                        if (pkt_valid) begin
                            parity_acc <= parity_acc ^ data_in;
                        end else begin
                            parity_rx <= data_in;
                            state     <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    error <= (parity_acc != parity_rx);
                    state <= DECODE;
                end
                DROP: begin
                    if (!pkt_valid) state <= DECODE;
                end
                default: state <= DECODE;
            endcase
        end
    end

endmodule

// File: tb/tb_modport_router.sv
// Bench for modport_router. It runs directed scenarios and randomized
// packets. Expected data comes from per-port byte queues filled from the
// packet rules: header, payload and parity all land in the addressed FIFO.
// Parity is the XOR of the header and payload.
module tb_modport_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  v_out;
    logic        busy;
    logic        error;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q2[$];
    logic [7:0]  pay[$];
    logic        exp_error;
    logic [23:0] exp_dout;

    modport_router #(.FIFO_DEPTH(16), .TIMEOUT(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .read_enb  (read_enb),
        .data_out  (data_out),
        .v_out     (v_out),
        .busy      (busy),
        .error     (error),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int p);
        case (p)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void push_exp(input int p, input logic [7:0] b);
        case (p)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] pop_exp(input int p);
        case (p)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic [2:0] exp_vout();
        return {q_size(2) != 0, q_size(1) != 0, q_size(0) != 0};
    endfunction

    function automatic logic [7:0] calc_parity(input logic [7:0] hdr);
        logic [7:0] x;
        x = hdr;
        foreach (pay[k]) x = x ^ pay[k];
        return x;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        exp_error = 1'b0;
        exp_dout  = '0;
    endtask

    // Present one byte and hold it until an edge with busy=0 takes it.
    task automatic send_byte(input logic [7:0] b, input logic v);
        int n;
        n = 0;
        data_in   = b;
        pkt_valid = v;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_wait", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // Send header (unless already sent), the payload in pay[], and the given
    // parity byte. Then check the error flag after the check cycle.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input logic hdr_done);
        logic valid_addr;
        valid_addr = (hdr[1:0] != 2'd3);
        if (valid_addr) begin
            push_exp(int'(hdr[1:0]), hdr);
            foreach (pay[k]) push_exp(int'(hdr[1:0]), pay[k]);
            push_exp(int'(hdr[1:0]), par);
            exp_error = (calc_parity(hdr) != par);
        end
        if (!hdr_done) begin
            send_byte(hdr, 1'b1);
            if (!valid_addr) check("busy_drop", {31'd0, busy}, 32'd0);
        end
        foreach (pay[k]) send_byte(pay[k], 1'b1);
        send_byte(par, 1'b0);
        pkt_valid = 1'b0;
        data_in   = '0;
        if (valid_addr) check("busy_check_state", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("error", {31'd0, error}, {31'd0, exp_error});
    endtask

    task automatic read_one(input int p);
        check("v_out_pre_read", {29'd0, v_out}, {29'd0, exp_vout()});
        read_enb = 3'(1 << p);
        @(negedge clk);
        read_enb = '0;
        if (q_size(p) != 0) exp_dout[8*p +: 8] = pop_exp(p);
        check("data_out", {8'd0, data_out}, {8'd0, exp_dout});
    endtask

    task automatic drain(input int p);
        int guard;
        guard = 0;
        while (q_size(p) != 0 && guard < 64) begin
            read_one(p);
            guard++;
        end
        check("v_out_drained", {29'd0, v_out}, {29'd0, exp_vout()});
    endtask

    // Stimulus
    initial begin
        int         p;
        int         len;
        logic [7:0] hdr;
        logic [7:0] par;

        rst = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
        exp_error = 1'b0; exp_dout = '0;

        // Reset state
        do_reset();
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_error", {31'd0, error},    32'd0);
        check("rst_v_out", {29'd0, v_out},    32'd0);
        check("rst_dout",  {8'd0, data_out},  32'd0);

        // Good packet to port 1
        pay = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 8'h0D, 1'b0);
        check("good_v_out", {29'd0, v_out}, 32'd2);
        drain(1);

        // Bad parity on the same packet
        send_packet(8'h0D, 8'h00, 1'b0);
        check("bad_error", {31'd0, error}, 32'd1);
        drain(1);

        // Invalid address: dropped, error holds its previous value
        pay = '{8'hAA, 8'hBB};
        send_packet(8'h07, 8'h12, 1'b0);
        check("inv_v_out", {29'd0, v_out}, 32'd0);
        check("inv_busy",  {31'd0, busy},  32'd0);

        // Reads on empty ports are ignored
        read_enb = 3'b111;
        @(negedge clk);
        read_enb = '0;
        check("empty_read_dout",  {8'd0, data_out}, {8'd0, exp_dout});
        check("empty_read_v_out", {29'd0, v_out},   32'd0);

        // Port 1 filled exactly, then a second header waits for it to empty
        pay.delete();
        for (int k = 0; k < 14; k++) pay.push_back(8'($urandom_range(0, 255)));
        hdr = {6'd14, 2'd1};
        send_packet(hdr, calc_parity(hdr), 1'b0);
        check("fill_v_out", {29'd0, v_out}, 32'd2);
        pay = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        hdr = {6'd2, 2'd1};
        send_byte(hdr, 1'b1);
        data_in = pay[0]; pkt_valid = 1'b1;
        check("wait_busy", {31'd0, busy}, 32'd1);
        drain(1);
        check("wait_busy_drained", {31'd0, busy}, 32'd1);
        send_packet(hdr, calc_parity(hdr), 1'b1);
        drain(1);

        // Random packets
        for (int it = 0; it < 24; it++) begin
            p   = $urandom_range(0, 5);
            if (p > 3) p = p - 3;
            len = $urandom_range(0, 12);
            pay.delete();
            for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
            hdr = {6'(len), 2'(p)};
            par = calc_parity(hdr);
            if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
            send_packet(hdr, par, 1'b0);
            check("rnd_v_out", {29'd0, v_out}, {29'd0, exp_vout()});
            if (p != 3) drain(p);
        end

        // Unread data on port 2
        pay.delete();
        send_packet(8'h02, 8'h02, 1'b0);
        repeat (40) @(negedge clk);
`ifdef MODPORT_ROUTER_SOFT_RESET_EN
        exp_q2.delete();
        check("soft_rst_v_out", {29'd0, v_out}, 32'd0);
        check("soft_rst_dout",  {8'd0, data_out}, {8'd0, exp_dout});
`else
        check("persist_v_out", {29'd0, v_out}, 32'd4);
        drain(2);
`endif

        // Full FIFO on port 0, release by one pop, then abort with reset
        send_byte(8'h50, 1'b1);
        for (int k = 0; k < 15; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        check("full_busy", {31'd0, busy}, 32'd1);
        data_in = 8'h5A; pkt_valid = 1'b1; read_enb = 3'b001;
        @(negedge clk);
        read_enb = '0;
        exp_dout[7:0] = 8'h50;
        check("full_release", {31'd0, busy}, 32'd0);
        check("full_pop",     {8'd0, data_out}, {8'd0, exp_dout});
        do_reset();
        check("midpkt_rst_v_out", {29'd0, v_out},   32'd0);
        check("midpkt_rst_busy",  {31'd0, busy},    32'd0);
        check("midpkt_rst_dout",  {8'd0, data_out}, 32'd0);
        check("midpkt_rst_error", {31'd0, error},   32'd0);

        // First valid byte after reset is a header
        pay = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        hdr = {6'd3, 2'd2};
        send_packet(hdr, calc_parity(hdr), 1'b0);
        check("post_rst_v_out", {29'd0, v_out}, 32'd4);
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
